vram_port_arbiter: RTL

//  Shares one single-port synchronous VRAM (80x30 text, 601 x 32-bit words, word 600 = control) between
//  the display glyph-fetch engine and the Avalon-MM CPU slave port. Display is real-time and wins by default.
//  CPU side is stalled with AVL_WAITREQUEST. Sits between the Avalon slave and the VRAM block.

---
 rtl/vram_port_arbiter.sv | 81 ++++++++
 1 files changed

// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter: shares one single-port VRAM between the display fetch engine and the Avalon CPU slave.
// Optional CPU aging (forced win after MAX_WAIT losses) is enabled by defining VRAM_ARB_AGING_EN.
module vram_port_arbiter #(
   parameter int ADDR_W    = 10,
   parameter int DATA_W    = 32,
   parameter int NUM_WORDS = 601,
   parameter int MAX_WAIT  = 4
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              AVL_CS,
   input  logic              AVL_READ,
   input  logic              AVL_WRITE,
   input  logic [3:0]        AVL_BYTE_EN,
   input  logic [ADDR_W-1:0] AVL_ADDR,
   input  logic [DATA_W-1:0] AVL_WRITEDATA,
   output logic [DATA_W-1:0] AVL_READDATA,
   output logic              AVL_WAITREQUEST,
   input  logic              DISP_REQ,
   input  logic [ADDR_W-1:0] DISP_ADDR,
   output logic              DISP_GNT,
   output logic              DISP_RVALID,
   output logic [DATA_W-1:0] DISP_RDATA,
   output logic [ADDR_W-1:0] RAM_ADDR,
   output logic              RAM_WE,
   output logic [3:0]        RAM_BE,
   output logic [DATA_W-1:0] RAM_WDATA,
   input  logic [DATA_W-1:0] RAM_RDATA
);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WORDS - 1);
   typedef enum logic [1:0] {IDLE, RD_ISSUED, RD_DONE} state_t;
   state_t state, state_nx;
   logic cpu_req, cpu_oor, disp_oor, aged, cpu_win, cpu_ram, lose, rd_oor, disp_oor_q;
   assign cpu_req  = AVL_CS & (AVL_READ | AVL_WRITE);
   assign cpu_oor  = AVL_ADDR > LAST;
   assign disp_oor = DISP_ADDR > LAST;
   // out-of-range CPU accesses never touch the RAM, so they never block the display
   assign cpu_win  = RESET_N & cpu_req & (state == IDLE) & (cpu_oor | ~DISP_REQ | aged);
   assign cpu_ram  = cpu_win & ~cpu_oor;
   assign lose     = RESET_N & cpu_req & (state == IDLE) & ~cpu_win;
   assign DISP_GNT = RESET_N & DISP_REQ & ~cpu_ram;
   assign RAM_WE    = cpu_ram & AVL_WRITE;
   assign RAM_ADDR  = DISP_GNT ? DISP_ADDR : cpu_ram ? AVL_ADDR : '0;
   assign RAM_BE    = RAM_WE ? AVL_BYTE_EN : 4'b0;
   assign RAM_WDATA = RAM_WE ? AVL_WRITEDATA : '0;
   assign AVL_WAITREQUEST = cpu_req & ~((cpu_win & AVL_WRITE) | (state == RD_DONE));
   assign DISP_RDATA = (DISP_RVALID & ~disp_oor_q) ? RAM_RDATA : '0;
   always_comb begin
      state_nx = IDLE;
      if (cpu_req)
         state_nx = (state == IDLE) ? ((cpu_win & AVL_READ) ? RD_ISSUED : IDLE) :
                    (state == RD_ISSUED) ? RD_DONE : IDLE;
   end
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state        <= IDLE;
         AVL_READDATA <= '0;
         DISP_RVALID  <= 1'b0;
         disp_oor_q   <= 1'b0;
         rd_oor       <= 1'b0;
      end else begin
         state       <= state_nx;
         DISP_RVALID <= DISP_GNT;
         disp_oor_q  <= disp_oor;
         if (cpu_win & AVL_READ) rd_oor <= cpu_oor;
         if ((state == RD_ISSUED) & cpu_req) AVL_READDATA <= rd_oor ? '0 : RAM_RDATA;
      end
   end
`ifdef VRAM_ARB_AGING_EN
   logic [2:0] wait_cnt;
   assign aged = wait_cnt == 3'(MAX_WAIT);
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) wait_cnt <= 3'd0;
      else wait_cnt <= lose ? ((wait_cnt == 3'd7) ? 3'd7 : wait_cnt + 3'd1) : 3'd0;
   end
`else
   assign aged = 1'b0;
   logic unused_lose;
   assign unused_lose = lose;
`endif
endmodule
